// File: rtl/frame_parser_mch_if.sv
// Handshake/bus bundle between the frame parser and its neighbours.
// The slave modport is the parser side; the master modport is the source/sink side.
// out_ch width follows NCH and must match the parser's NCH.
interface frame_parser_mch_if #(
  parameter int NCH = 8
);
  logic [15:0]    data_in;
  logic           data_in_vld;
  logic [15:0]    out_data;
  logic [NCH-1:0] out_ch;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           crc_valid_o;
  logic           crc_err;
  logic           frame_err;
  logic           busy;

  modport slave (
    input  data_in, data_in_vld, out_ready,
    output out_data, out_ch, out_valid, out_last,
           crc_valid_o, crc_err, frame_err, busy
  );

  modport master (
    output data_in, data_in_vld, out_ready,
    input  out_data, out_ch, out_valid, out_last,
           crc_valid_o, crc_err, frame_err, busy
  );
endinterface

// File: rtl/frame_parser_mch.sv
// Purpose: hunts HEADER, latches a one-hot channel, buffers payload+CRC up to TRAILER,
//          checks CRC-16/CCITT and drains the payload tagged with the channel.
// Latency: first out_valid P+2 cycles after the cycle carrying TRAILER[15:0].
// Backpressure: drain holds word/channel/last while out_ready is low; input is
//          dropped while busy (CHECK/CMP/DRAIN).
// Optional: define GRAY_OUT_EN to Gray-code the drained payload; otherwise raw words.
module frame_parser_mch #(
  parameter int          NCH       = 8,
  parameter int          MAX_WORDS = 8,
  parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
  parameter logic [31:0] TRAILER   = 32'h0E0E0E0E,
  parameter logic [15:0] CRC_INIT  = 16'h0000
) (
  input  logic                clk_in,
  input  logic                rst_n,
  frame_parser_mch_if.slave   bus
);

  // payload + CRC word + two trailer halves
  localparam int DEPTH = MAX_WORDS + 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);
  localparam logic [CW-1:0] THREE   = CW'(3);
  localparam logic [15:0]   CH_MASK = 16'((32'd1 << NCH) - 32'd1);

  typedef enum logic [2:0] {HUNT, HDR2, CHAN, BODY, CHECK, CMP, DRAIN} state_t;

  state_t         state_q;
  logic [15:0]    mem_q [DEPTH];
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  p_q;
  logic [CW-1:0]  idx_q;
  logic [15:0]    prev_q;
  logic [15:0]    crc_q;
  logic [NCH-1:0] ch_q;
  logic [15:0]    out_data_q;
  logic [NCH-1:0] out_ch_q;
  logic           out_valid_q;
  logic           out_last_q;
  logic           crc_valid_q;
  logic           crc_err_q;
  logic           frame_err_q;
  logic           busy_q;
`ifdef GRAY_OUT_EN
  logic           lsb_q;
`endif

  logic [15:0]    crc_d;
  logic [CW-1:0]  idx_d;
  logic           chan_ok;
  logic           trl_hit;

  // one 16-bit word through poly 0x1021, MSB first
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      r = {r[14:0], 1'b0} ^ (((r[15] ^ d[b]) == 1'b1) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

`ifdef GRAY_OUT_EN
  // Gray across word boundaries: the previous word's LSB feeds this word's MSB
  function automatic logic [15:0] code_word(input logic [15:0] w, input logic lsb);
    return w ^ {lsb, w[15:1]};
  endfunction
`endif

  assign crc_d   = crc_step(crc_q, mem_q[idx_q]);
  assign idx_d   = idx_q + ONE;
  assign chan_ok = ((bus.data_in & ~CH_MASK) == 16'h0000) && (bus.data_in != 16'h0000) &&
                   ((bus.data_in & (bus.data_in - 16'd1)) == 16'h0000);
  assign trl_hit = (bus.data_in == TRAILER[15:0]) && (prev_q == TRAILER[31:16]) &&
                   (cnt_q >= THREE);

  assign bus.out_data    = out_data_q;
  assign bus.out_ch      = out_ch_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.crc_valid_o = crc_valid_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;

  // frame buffer: every accepted BODY word lands at the current count
  always_ff @(posedge clk_in) begin
    if (state_q == BODY && bus.data_in_vld) begin
      mem_q[cnt_q] <= bus.data_in;
    end
  end

  // parser FSM with registered outputs and pulses
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      p_q         <= '0;
      idx_q       <= '0;
      prev_q      <= '0;
      crc_q       <= CRC_INIT;
      ch_q        <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef GRAY_OUT_EN
      lsb_q       <= 1'b0;
`endif
    end else begin
      crc_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (bus.data_in_vld && bus.data_in == HEADER[31:16]) state_q <= HDR2;
        end
        HDR2: begin
          if (bus.data_in_vld) begin
            if (bus.data_in == HEADER[15:0])       state_q <= CHAN;
            else if (bus.data_in == HEADER[31:16]) state_q <= HDR2;
            else                                   state_q <= HUNT;
          end
        end
        CHAN: begin
          if (bus.data_in_vld) begin
            if (chan_ok) begin
              ch_q    <= bus.data_in[NCH-1:0];
              cnt_q   <= '0;
              state_q <= BODY;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
            end
          end
        end
        BODY: begin
          if (bus.data_in_vld) begin
            prev_q <= bus.data_in;
            if (trl_hit) begin
              p_q     <= cnt_q - TWO;
              idx_q   <= '0;
              crc_q   <= CRC_INIT;
              busy_q  <= 1'b1;
              state_q <= CHECK;
            end else if (cnt_q + ONE == DEPTH_C) begin
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
        end
        CHECK: begin
          crc_q <= crc_d;
          idx_q <= idx_d;
          if (idx_q == p_q - ONE) begin
            idx_q   <= '0;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (crc_q == mem_q[p_q]) begin
            crc_valid_q <= 1'b1;
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_q;
            out_last_q  <= (p_q == ONE);
`ifdef GRAY_OUT_EN
            out_data_q  <= code_word(mem_q[0], 1'b0);
            lsb_q       <= mem_q[0][0];
`else
            out_data_q  <= mem_q[0];
`endif
            state_q     <= DRAIN;
          end else begin
            crc_err_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= HUNT;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_ch_q    <= '0;
              out_data_q  <= '0;
              busy_q      <= 1'b0;
              state_q     <= HUNT;
            end else begin
              idx_q      <= idx_d;
              out_last_q <= (idx_d == p_q - ONE);
`ifdef GRAY_OUT_EN
              out_data_q <= code_word(mem_q[idx_d], lsb_q);
              lsb_q      <= mem_q[idx_d][0];
`else
              out_data_q <= mem_q[idx_d];
`endif
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

endmodule

// File: doc/frame_parser_mch.md
Name: frame_parser_mch

Overview:
- Single-clock, parametrised successor of the serial-output frame detector.
- Hunts header E0E0E0E0 on a 16-bit Big-Endian input stream, latches a one-hot channel word, and buffers a variable-length payload terminated by CRC + trailer 0E0E0E0E.
- Checks CRC-16/CCITT over the payload, then drains the payload as Gray-coded 16-bit words on a valid/ready output tagged with the channel.
- Sits between the input capture and the per-channel serialisers; NCH and depth are generalised.

Parameters:
NCH, 8, number of output channels (1..16); channel word bits [NCH-1:0] are one-hot.
MAX_WORDS, 8, maximum payload length in 16-bit words (1..32).
HEADER, 32'hE0E0E0E0, frame header, sent high half first.
TRAILER, 32'h0E0E0E0E, frame trailer, sent high half first.
CRC_INIT, 16'h0000, CRC register seed.

Ports:
clk_in  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
data_in  input  16  input word.
data_in_vld  input  1  data_in qualifier; the FSM advances only when this is 1.
out_data  output  16  payload word, Gray-coded.
out_ch  output  NCH  one-hot channel of the current frame.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream accept.
out_last  output  1  final payload word of the frame.
crc_valid_o  output  1  1-cycle pulse: CRC matched, drain starts.
crc_err  output  1  1-cycle pulse: CRC mismatch, frame discarded.
frame_err  output  1  1-cycle pulse: bad channel word or length overflow.
busy  output  1  1 in CHECK, CMP and DRAIN; input is ignored.

Behaviour:
- Reset: all outputs are 0, the FSM is in HUNT, and the buffer count is 0. An asserted reset aborts any state immediately.
- FSM states: HUNT, HDR2, CHAN, BODY, CHECK, CMP, DRAIN. Valid input words are consumed only in HUNT, HDR2, CHAN and BODY.
- HUNT: a word equal to HEADER[31:16] moves to HDR2.
- HDR2: a word equal to HEADER[15:0] moves to CHAN. A word equal to HEADER[31:16] stays in HDR2. Any other word returns to HUNT.
- CHAN: channel word check.
  - If bits [15:NCH] are 0 and bits [NCH-1:0] are exactly one-hot: latch the channel, clear the count, and go to BODY.
  - Otherwise pulse frame_err and go to HUNT.
- BODY: each word is stored at buf[cnt] and cnt increments.
  - The trailer is detected when the current word == TRAILER[15:0], the previous word == TRAILER[31:16], and cnt >= 3 before the store.
  - On trailer detect: P = cnt-2 payload words, the CRC word is buf[P], and the FSM goes to CHECK.
  - The earliest qualifying match terminates the frame.
  - A trailer pattern with cnt < 3 is treated as data.
  - If cnt reaches MAX_WORDS+3 without a trailer: pulse frame_err and go to HUNT.
- CHECK: feeds buf[0..P-1] one word per cycle (P cycles) into a 16-bit-parallel CRC.
  - Polynomial 0x1021, MSB-first, seed CRC_INIT, no final XOR.
- CMP: one cycle; compares the CRC against buf[P].
  - Match: pulse crc_valid_o and go to DRAIN.
  - Mismatch: pulse crc_err and go to HUNT.
- DRAIN: out_valid=1, out_ch=latched channel, out_data = coded word i (i starts at 0).
  - i advances on out_valid & out_ready.
  - out_last=1 when i=P-1.
  - The handshake on the last word returns the FSM to HUNT on the next cycle; out_valid, out_ch and out_last drop to 0.
  - While stalled, out_data, out_ch and out_last hold stable.
- Gray rule: the whole payload is treated as one P*16-bit vector. out word k = w_k ^ {w_(k-1)[0], w_k[15:1]}, with w_(-1)[0]=0. This equals bin^(bin>>1) over the full Big-Endian vector.
- Latency: the first out_valid appears P+2 cycles after the cycle carrying TRAILER[15:0].
- Simultaneity: data_in_vld during busy is dropped. A header arriving during DRAIN is lost; no queuing.

Optional Feature:
GRAY_OUT_EN:
- Defined: out_data is Gray-coded per the rule above.
- Undefined: out_data = w_k raw binary; the Gray logic and the previous-LSB register are removed. All other timing is identical.

Test Plan:
- Channel 0x01, payload A55A, correct CRC -> crc_valid_o pulse; one word out_data=F7F7 with out_last=1, out_ch=0x01.
- Channel 0x02, payload 1111,A55A, correct CRC -> out words 1999 then 77F7; out_last only on the second word. With GRAY_OUT_EN undefined -> 1111, A55A.
- Payload 1234 with CRC word FFFF -> crc_err pulse; out_valid never asserts; next good frame parses normally.
- Channel word 0x0003, then 0x0100 with NCH=8 -> frame_err pulse each time; no output.
- MAX_WORDS=8, 12 payload words and no trailer -> frame_err when cnt=11; parser back in HUNT.
- 8-word payload with out_ready toggling 1/0 and rst_n pulsed low mid-DRAIN -> data holds while stalled; after reset all outputs are 0 and the next frame is accepted.
